// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: op codes, FSM states, flag bit positions.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_ADC   = 4'd1,
    OP_SUB   = 4'd2,
    OP_SBC   = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_XOR   = 4'd6,
    OP_PASSL = 4'd7,
    OP_PASSR = 4'd8,
    OP_MUL   = 4'd9,
    OP_MULH  = 4'd10
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 2;
  localparam int FLG_V = 3;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier, one partial product per cycle over WIDTH cycles.
// o_prod is the accumulator value after the current step, so it is final when o_done is high.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_prod
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] r_a;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic [2*WIDTH-1:0] w_acc_nxt;

  assign w_acc_nxt = r_acc + (r_b[0] ? r_a : '0);
  assign o_prod    = w_acc_nxt;
  assign o_done    = r_busy && (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_acc  <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_a    <= {{WIDTH{1'b0}}, i_a};
      r_acc  <= '0;
      r_b    <= i_b;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_acc <= w_acc_nxt;
      r_a   <= r_a << 1;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt + CW'(1);
      if (o_done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_stage.sv
// Execute stage: registered result + C/Z/N/V flags behind a valid/ready handshake.
// Define ALU_MUL_EN to build the multi-cycle MUL/MULH path; otherwise ops 9/10 are reserved.
module alu_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             validIn,
  output logic             readyOut,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] LhsIn,
  input  logic [WIDTH-1:0] RhsIn,
  input  logic             carryIn,
  output logic             validOut,
  input  logic             readyIn,
  output logic [WIDTH-1:0] resultOut,
  output logic             carryOut,
  output logic             zeroOut,
  output logic             negOut,
  output logic             overflowOut
);

  logic             r_valid;
  logic [WIDTH-1:0] r_res;
  logic [3:0]       r_flags;

  logic             w_accept;
  logic             w_load;
  logic             w_sub;
  logic             w_cin;
  logic [WIDTH-1:0] w_rhs;
  logic [WIDTH:0]   w_sum;
  logic             w_v_arith;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic [WIDTH-1:0] w_ld_res;
  logic [3:0]       w_ld_flags;

  assign w_accept = validIn && readyOut;

  // Subtraction is L + ~R + cin, so one signed-overflow rule covers add and sub.
  assign w_sub     = (op == OP_SUB) || (op == OP_SBC);
  assign w_rhs     = w_sub ? ~RhsIn : RhsIn;
  assign w_cin     = (op == OP_SUB) ? 1'b1 : ((op == OP_ADC) || (op == OP_SBC)) ? carryIn : 1'b0;
  assign w_sum     = {1'b0, LhsIn} + {1'b0, w_rhs} + {{WIDTH{1'b0}}, w_cin};
  assign w_v_arith = (LhsIn[WIDTH-1] == w_rhs[WIDTH-1]) && (w_sum[WIDTH-1] != LhsIn[WIDTH-1]);

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = w_v_arith;
      end
      OP_AND:   w_res = LhsIn & RhsIn;
      OP_OR:    w_res = LhsIn | RhsIn;
      OP_XOR:   w_res = LhsIn ^ RhsIn;
      OP_PASSL: begin
        w_res = LhsIn;
        w_c   = carryIn;
      end
      OP_PASSR: w_res = RhsIn;
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_mulh;
  logic               w_is_mul;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;

  assign w_is_mul = (op == OP_MUL) || (op == OP_MULH);
  assign readyOut = (r_state == ST_IDLE) && (!r_valid || readyIn);
  assign w_load   = (w_accept && !w_is_mul) || w_mul_done;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_accept && w_is_mul),
    .i_a     (LhsIn),
    .i_b     (RhsIn),
    .o_done  (w_mul_done),
    .o_prod  (w_prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mulh  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_mulh <= (op == OP_MULH);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && w_is_mul) w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_mul_done) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ld_res   = w_res;
    w_ld_flags = '0;
    w_ld_flags[FLG_C] = w_c;
    w_ld_flags[FLG_V] = w_v;
    if (r_state == ST_BUSY) begin
      w_ld_res          = r_mulh ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
      w_ld_flags[FLG_C] = !r_mulh && (|w_prod[2*WIDTH-1:WIDTH]);
      w_ld_flags[FLG_V] = 1'b0;
    end
    w_ld_flags[FLG_Z] = ~|w_ld_res;
    w_ld_flags[FLG_N] = w_ld_res[WIDTH-1];
  end
`else
  assign readyOut = !r_valid || readyIn;
  assign w_load   = w_accept;

  always_comb begin
    w_ld_res   = w_res;
    w_ld_flags = '0;
    w_ld_flags[FLG_C] = w_c;
    w_ld_flags[FLG_V] = w_v;
    w_ld_flags[FLG_Z] = ~|w_res;
    w_ld_flags[FLG_N] = w_res[WIDTH-1];
  end
`endif

  // An accept that does not load is a multiply start: the old result retires, data stays.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_res   <= '0;
      r_flags <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_res   <= w_ld_res;
      r_flags <= w_ld_flags;
    end else if (w_accept || (r_valid && readyIn)) begin
      r_valid <= 1'b0;
    end
  end

  assign validOut    = r_valid;
  assign resultOut   = r_res;
  assign carryOut    = r_flags[FLG_C];
  assign zeroOut     = r_flags[FLG_Z];
  assign negOut      = r_flags[FLG_N];
  assign overflowOut = r_flags[FLG_V];

endmodule

// File: doc/alu_stage.md
Name: alu_stage

Overview:
- Execute stage directly downstream of the LHS shift stage.
- Consumes the shifted LHS operand and its carry, plus a RHS operand and an op code.
- Computes an 8-bit result and C/Z/N/V flags into a registered output with a valid/ready handshake.
- Optional shift-add multiplier makes selected ops multi-cycle; the stage back-pressures upstream while busy or while its output is unconsumed.

Parameters:
WIDTH, 8, operand/result width in bits (the multiplier iterates WIDTH cycles)

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  reset, asynchronous, active-high
validIn  input  1  upstream presents an operation
readyOut  output  1  stage can accept an operation this cycle
op  input  4  operation code (see Behaviour)
LhsIn  input  WIDTH  left operand (from shift stage LhsOut)
RhsIn  input  WIDTH  right operand
carryIn  input  1  carry from shift stage carryOut
validOut  output  1  result/flags valid
readyIn  input  1  downstream accepts result
resultOut  output  WIDTH  registered result
carryOut  output  1  C flag
zeroOut  output  1  Z flag, set when resultOut == 0
negOut  output  1  N flag, equal to resultOut[WIDTH-1]
overflowOut  output  1  V flag, signed overflow

Behaviour:
- Reset: state IDLE, validOut=0, resultOut=0, carryOut=0, zeroOut=0, negOut=0, overflowOut=0. Reset during BUSY aborts the multiply; the partial product is discarded.
- readyOut = (state==IDLE) && (!validOut || readyIn), purely combinational.
- Accept occurs on a rising edge where validIn && readyOut. Operands and op are captured at accept.
- Ops:
  - 0 ADD: L+R. C = carry out.
  - 1 ADC: L+R+carryIn.
  - 2 SUB: L-R. C = 1 when no borrow (L>=R unsigned).
  - 3 SBC: L-R-(~carryIn).
  - 4 AND, 5 OR, 6 XOR: C=0, V=0.
  - 7 PASSL: result = L. C = carryIn (forwards the shift carry). V=0.
  - 8 PASSR: result = R. C=0, V=0.
  - 9 MUL: low half of L*R unsigned. C = (high half != 0). V=0.
  - 10 MULH: high half of L*R. C=0, V=0.
  - 11-15 reserved: result 0, Z=1, C=N=V=0.
- Arithmetic is computed at WIDTH+1 bits; bit WIDTH is the carry.
- V for add: operands share a sign and the result sign differs. V for sub: operand signs differ and the result sign differs from L.
- Z and N are always derived from the final result.
- Single-cycle ops: result and flags register on the accept edge; validOut=1 from the following cycle (latency 1).
- FSM:
  - IDLE: on accept of a single-cycle op, stay IDLE and load outputs. On accept of op 9/10, go to BUSY, counter=0, validOut cleared.
  - BUSY: one shift-add iteration per cycle. When the counter reaches WIDTH-1, load outputs, set validOut, return to IDLE. validOut therefore rises WIDTH edges after the accept edge. readyOut=0 throughout BUSY.
- Output hold: while validOut && !readyIn, resultOut and all flags are frozen and no new op is accepted.
- Simultaneous consume + accept (validOut && readyIn && validIn, IDLE): the old result retires and the new op is accepted on the same edge.
  - Single-cycle op: validOut stays 1 with new data.
  - MUL: validOut drops to 0 until done.
- When validOut && readyIn && no accept: validOut clears, data registers keep their values.

Optional Feature:
ALU_MUL_EN
- Defined: ops 9/10 use the BUSY multiplier as specified.
- Undefined: no multiplier logic and no BUSY state. Ops 9/10 behave as reserved (single-cycle, result 0, Z=1), and readyOut depends only on output occupancy.

Decomposition:
- Package alu_pkg: op code constants/enum (ADD..MULH), FSM state enum (IDLE, BUSY), default WIDTH, flag bit index constants.
- One sub-module: alu_mul_seq.
  - Shift-add multiplier with start, done, a, b, and a 2*WIDTH product.
  - Instantiated only under ALU_MUL_EN.

Test Plan:
- ADD L=0x7F R=0x01 -> resultOut=0x80, C0 Z0 N1 V1; validOut high exactly 1 cycle after accept.
- SBC L=0x10 R=0x0F carryIn=0 -> 0x00, C1 Z1 N0 V0. SUB L=0x10 R=0x20 -> 0xF0, C0 N1 V0.
- MUL L=0xFF R=0xFF -> 0x01 with C1. MULH same operands -> 0xFE with C0. validOut rises 8 edges after accept; readyOut=0 throughout.
- Backpressure: result valid, readyIn held low 3 cycles -> outputs stable, readyOut=0. readyIn=1 with validIn=1 (ADD 0x01+0x01) -> 0x02 on the next cycle, validOut continuous.
- Reset asserted 4 cycles into a MUL -> validOut=0 and all outputs 0 immediately. After release, readyOut=1, and ADD 0x00+0x00 -> Z1.
- Built without ALU_MUL_EN: op 9 L=0x03 R=0x03 -> 0x00, Z1, latency 1. Op 15 with the macro defined -> 0x00, Z1.
